ram_bus_arbiter: RTL and testbench

Shares the single serial RAM port (ram_nss/ram_sck/ram_mosi/ram_miso) between the MCU-side and coprocessor-side RAM access engines inside the core logic. Each requester runs a req/grant handshake and drives its own SPI bundle. The arbiter routes exactly one bundle to the RAM pins and enforces an nss-high gap between owners. A hold timeout stops one side from starving the other.

---
 rtl/ram_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: routes one of two requester SPI bundles (MCU engine or coprocessor
// engine) onto the single serial RAM port, with an nss-high gap between owners and an
// optional hold timeout so a busy owner cannot starve the other side.
module ram_bus_arbiter #(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned MCU_PRIORITY   = 0
) (
    input  logic clk,
    input  logic reset,

    input  logic mcu_req,
    output logic mcu_grant,
    input  logic mcu_ram_nss,
    input  logic mcu_ram_sck,
    input  logic mcu_ram_mosi,
    output logic mcu_ram_miso,

    input  logic cop_req,
    output logic cop_grant,
    input  logic cop_ram_nss,
    input  logic cop_ram_sck,
    input  logic cop_ram_mosi,
    output logic cop_ram_miso,

    output logic ram_nss,
    output logic ram_sck,
    output logic ram_mosi,
    input  logic ram_miso,

    output logic timeout_pulse,
    output logic busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OWN_MCU = 2'd1;
    localparam logic [1:0] OWN_COP = 2'd2;
    localparam logic [1:0] GAP     = 2'd3;

    localparam logic OWNER_MCU = 1'b0;
    localparam logic OWNER_COP = 1'b1;

    localparam int unsigned HOLD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(TIMEOUT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic              last_owner_q, last_owner_d;
    // Set by a revocation: the next tie goes round-robin even with MCU priority.
    logic              force_rr_q, force_rr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              ram_nss_q, ram_nss_d;
    logic              ram_sck_q, ram_sck_d;
    logic              ram_mosi_q, ram_mosi_d;
    logic              timeout_pulse_q, timeout_pulse_d;

    logic own_cop;
    logic owner_req;
    logic other_req;
    logic owner_nss;
    logic owner_sck;
    logic owner_mosi;
    logic pick_cop;

    // Select the current owner's request and SPI bundle.
    always_comb begin
        own_cop    = (state_q == OWN_COP);
        owner_req  = own_cop ? cop_req : mcu_req;
        other_req  = own_cop ? mcu_req : cop_req;
        owner_nss  = own_cop ? cop_ram_nss : mcu_ram_nss;
        owner_sck  = own_cop ? cop_ram_sck : mcu_ram_sck;
        owner_mosi = own_cop ? cop_ram_mosi : mcu_ram_mosi;
    end

    // Arbitration, ownership, release/revocation and gap sequencing.
    always_comb begin
        state_d         = state_q;
        last_owner_d    = last_owner_q;
        force_rr_d      = force_rr_q;
        hold_d          = hold_q;
        gap_d           = gap_q;
        timeout_pulse_d = 1'b0;
        ram_nss_d       = 1'b1;
        ram_sck_d       = 1'b0;
        ram_mosi_d      = 1'b0;
        pick_cop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mcu_req && cop_req) begin
                    if ((MCU_PRIORITY != 0) && !force_rr_q) begin
                        pick_cop = 1'b0;
                    end else begin
                        pick_cop = (last_owner_q == OWNER_MCU);
                    end
                end else begin
                    pick_cop = cop_req;
                end
                if (mcu_req || cop_req) begin
                    state_d      = pick_cop ? OWN_COP : OWN_MCU;
                    last_owner_d = pick_cop ? OWNER_COP : OWNER_MCU;
                    force_rr_d   = 1'b0;
                    hold_d       = '0;
                end
            end

            OWN_MCU, OWN_COP: begin
                if (!owner_req) begin
                    // Release wins over a coincident timeout.
                    state_d = GAP;
                    gap_d   = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (hold_q >= HOLD_LAST) && other_req) begin
                    state_d         = GAP;
                    gap_d           = '0;
                    timeout_pulse_d = 1'b1;
                    force_rr_d      = 1'b1;
                end else begin
                    ram_nss_d  = owner_nss;
                    ram_sck_d  = owner_sck;
                    ram_mosi_d = owner_mosi;
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State registers and registered RAM pins with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            last_owner_q    <= OWNER_COP;
            force_rr_q      <= 1'b0;
            hold_q          <= '0;
            gap_q           <= '0;
            ram_nss_q       <= 1'b1;
            ram_sck_q       <= 1'b0;
            ram_mosi_q      <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_owner_q    <= last_owner_d;
            force_rr_q      <= force_rr_d;
            hold_q          <= hold_d;
            gap_q           <= gap_d;
            ram_nss_q       <= ram_nss_d;
            ram_sck_q       <= ram_sck_d;
            ram_mosi_q      <= ram_mosi_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign mcu_grant     = (state_q == OWN_MCU);
    assign cop_grant     = (state_q == OWN_COP);
    assign mcu_ram_miso  = ram_miso & mcu_grant;
    assign cop_ram_miso  = ram_miso & cop_grant;
    assign ram_nss       = ram_nss_q;
    assign ram_sck       = ram_sck_q;
    assign ram_mosi      = ram_mosi_q;
    assign timeout_pulse = timeout_pulse_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: instance a is round-robin with a long timeout,
// instance b has MCU priority and a 16-cycle timeout.
module tb_ram_bus_arbiter;

    logic clk = 1'b0;
    logic reset;

    logic a_mcu_req, a_mcu_grant, a_mcu_nss, a_mcu_sck, a_mcu_mosi, a_mcu_miso;
    logic a_cop_req, a_cop_grant, a_cop_nss, a_cop_sck, a_cop_mosi, a_cop_miso;
    logic a_ram_nss, a_ram_sck, a_ram_mosi, a_ram_miso, a_timeout, a_busy;

    logic b_mcu_req, b_mcu_grant, b_mcu_nss, b_mcu_sck, b_mcu_mosi, b_mcu_miso;
    logic b_cop_req, b_cop_grant, b_cop_nss, b_cop_sck, b_cop_mosi, b_cop_miso;
    logic b_ram_nss, b_ram_sck, b_ram_mosi, b_ram_miso, b_timeout, b_busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_on   = 1'b0;
    logic rr_on    = 1'b0;
    int   nss_run  = 0;
    logic seen_low = 1'b0;

    always #5 clk = ~clk;

    ram_bus_arbiter #(
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(64),
        .MCU_PRIORITY  (0)
    ) dut_a (
        .clk          (clk),
        .reset        (reset),
        .mcu_req      (a_mcu_req),
        .mcu_grant    (a_mcu_grant),
        .mcu_ram_nss  (a_mcu_nss),
        .mcu_ram_sck  (a_mcu_sck),
        .mcu_ram_mosi (a_mcu_mosi),
        .mcu_ram_miso (a_mcu_miso),
        .cop_req      (a_cop_req),
        .cop_grant    (a_cop_grant),
        .cop_ram_nss  (a_cop_nss),
        .cop_ram_sck  (a_cop_sck),
        .cop_ram_mosi (a_cop_mosi),
        .cop_ram_miso (a_cop_miso),
        .ram_nss      (a_ram_nss),
        .ram_sck      (a_ram_sck),
        .ram_mosi     (a_ram_mosi),
        .ram_miso     (a_ram_miso),
        .timeout_pulse(a_timeout),
        .busy         (a_busy)
    );

    ram_bus_arbiter #(
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(16),
        .MCU_PRIORITY  (1)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .mcu_req      (b_mcu_req),
        .mcu_grant    (b_mcu_grant),
        .mcu_ram_nss  (b_mcu_nss),
        .mcu_ram_sck  (b_mcu_sck),
        .mcu_ram_mosi (b_mcu_mosi),
        .mcu_ram_miso (b_mcu_miso),
        .cop_req      (b_cop_req),
        .cop_grant    (b_cop_grant),
        .cop_ram_nss  (b_cop_nss),
        .cop_ram_sck  (b_cop_sck),
        .cop_ram_mosi (b_cop_mosi),
        .cop_ram_miso (b_cop_miso),
        .ram_nss      (b_ram_nss),
        .ram_sck      (b_ram_sck),
        .ram_mosi     (b_ram_mosi),
        .ram_miso     (b_ram_miso),
        .timeout_pulse(b_timeout),
        .busy         (b_busy)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for either grant of one instance; n = edges until the grant.
    task automatic wait_grant(input logic use_b, output logic got_cop, output int n);
        logic ok;
        ok      = 1'b0;
        got_cop = 1'b0;
        n       = 0;
        while (!ok && n < 10) begin
            tick();
            n++;
            if (use_b ? (b_mcu_grant | b_cop_grant) : (a_mcu_grant | a_cop_grant)) begin
                ok      = 1'b1;
                got_cop = use_b ? b_cop_grant : a_cop_grant;
            end
        end
        check("grant_seen", ok, 1'b1);
    endtask

    // Grants never overlap; between round-robin owners ram_nss stays high >= 3 cycles.
    always @(negedge clk) begin
        if (mon_on) begin
            check("a_excl", a_mcu_grant & a_cop_grant, 1'b0);
            check("b_excl", b_mcu_grant & b_cop_grant, 1'b0);
            if (rr_on) begin
                if (a_ram_nss) begin
                    nss_run++;
                end else begin
                    if (seen_low && nss_run != 0) check("a_nss_gap", nss_run >= 3, 1'b1);
                    nss_run  = 0;
                    seen_low = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] bytes [3];
        logic       exp_cop [3];
        logic [7:0] byte_v;
        logic       got_cop;
        int         n;

        bytes[0] = 8'h03; bytes[1] = 8'h00; bytes[2] = 8'h29;
        exp_cop[0] = 1'b1; exp_cop[1] = 1'b0; exp_cop[2] = 1'b1;

        reset = 1'b1;
        a_mcu_req = 1'b1; a_mcu_nss = 1'b1; a_mcu_sck = 1'b0; a_mcu_mosi = 1'b0;
        a_cop_req = 1'b1; a_cop_nss = 1'b1; a_cop_sck = 1'b0; a_cop_mosi = 1'b0;
        b_mcu_req = 1'b1; b_mcu_nss = 1'b1; b_mcu_sck = 1'b0; b_mcu_mosi = 1'b0;
        b_cop_req = 1'b1; b_cop_nss = 1'b1; b_cop_sck = 1'b0; b_cop_mosi = 1'b0;
        a_ram_miso = 1'b0; b_ram_miso = 1'b0;

        // Reset held with both sides requesting.
        repeat (2) tick();
        check("rst_a_mcu_grant", a_mcu_grant, 1'b0);
        check("rst_a_cop_grant", a_cop_grant, 1'b0);
        check("rst_a_nss", a_ram_nss, 1'b1);
        check("rst_a_sck", a_ram_sck, 1'b0);
        check("rst_a_busy", a_busy, 1'b0);
        check("rst_b_mcu_grant", b_mcu_grant, 1'b0);
        check("rst_b_cop_grant", b_cop_grant, 1'b0);
        check("rst_b_nss", b_ram_nss, 1'b1);
        check("rst_b_timeout", b_timeout, 1'b0);
        mon_on = 1'b1;

        // First tie after reset goes to MCU.
        reset = 1'b0;
        tick();
        check("first_a_mcu", a_mcu_grant, 1'b1);
        check("first_a_cop", a_cop_grant, 1'b0);
        check("first_b_mcu", b_mcu_grant, 1'b1);
        check("first_b_cop", b_cop_grant, 1'b0);
        a_mcu_req = 1'b0; a_cop_req = 1'b0; b_mcu_req = 1'b0; b_cop_req = 1'b0;
        repeat (4) tick();
        check("idle_a_busy", a_busy, 1'b0);
        check("idle_b_busy", b_busy, 1'b0);

        // Single MCU transfer of 0x03,0x00,0x29; RAM answers with inverted mosi.
        a_mcu_req = 1'b1;
        tick();
        check("xfer_grant", a_mcu_grant, 1'b1);
        check("xfer_cop_grant", a_cop_grant, 1'b0);
        for (int k = 0; k < 3; k++) begin
            byte_v = bytes[k];
            for (int i = 7; i >= 0; i--) begin
                for (int ph = 0; ph < 2; ph++) begin
                    a_mcu_nss  = 1'b0;
                    a_mcu_sck  = ph[0];
                    a_mcu_mosi = byte_v[i];
                    tick();
                    check("xfer_mosi", a_ram_mosi, byte_v[i]);
                    check("xfer_sck", a_ram_sck, ph[0]);
                    check("xfer_nss", a_ram_nss, 1'b0);
                    a_ram_miso = ~byte_v[i];
                    #1;
                    check("xfer_mcu_miso", a_mcu_miso, ~byte_v[i]);
                    check("xfer_cop_miso", a_cop_miso, 1'b0);
                end
            end
        end
        a_mcu_nss = 1'b1; a_mcu_sck = 1'b0; a_mcu_mosi = 1'b0;
        tick();
        check("xfer_end_nss", a_ram_nss, 1'b1);
        a_mcu_req = 1'b0;
        tick();
        check("rel_grant", a_mcu_grant, 1'b0);
        check("rel_nss", a_ram_nss, 1'b1);
        check("rel_busy", a_busy, 1'b1);
        a_ram_miso = 1'b0;
        repeat (2) tick();
        check("rel_idle", a_busy, 1'b0);

        // Round-robin contention; MCU owned last, so COP, MCU, COP.
        rr_on = 1'b1;
        a_mcu_req = 1'b1; a_cop_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(1'b0, got_cop, n);
            check("rr_owner", got_cop, exp_cop[k]);
            check("rr_latency", n == ((k == 0) ? 1 : 3), 1'b1);
            if (got_cop) a_cop_nss = 1'b0; else a_mcu_nss = 1'b0;
            repeat (19) tick();
            if (got_cop) a_cop_nss = 1'b1; else a_mcu_nss = 1'b1;
            tick();
            if (got_cop) a_cop_req = 1'b0; else a_mcu_req = 1'b0;
            tick();
            check("rr_drop", got_cop ? a_cop_grant : a_mcu_grant, 1'b0);
            check("rr_timeout", a_timeout, 1'b0);
            a_mcu_req = 1'b1; a_cop_req = 1'b1;
        end
        a_mcu_req = 1'b0; a_cop_req = 1'b0;
        rr_on = 1'b0;
        repeat (5) tick();

        // Fixed priority: MCU wins a tie even though it owned last.
        b_mcu_req = 1'b1; b_cop_req = 1'b1;
        tick();
        check("pri_mcu", b_mcu_grant, 1'b1);
        check("pri_cop", b_cop_grant, 1'b0);
        repeat (5) begin
            tick();
            check("pri_cop_wait", b_cop_grant, 1'b0);
        end
        b_mcu_req = 1'b0;
        tick();
        check("pri_rel", b_mcu_grant, 1'b0);
        wait_grant(1'b1, got_cop, n);
        check("pri_cop_after", got_cop, 1'b1);
        check("pri_cop_lat", n == 3, 1'b1);
        b_cop_req = 1'b0;
        repeat (4) tick();

        // Timeout: MCU holds, COP requests from grant edge G.
        b_mcu_req = 1'b1;
        tick();
        check("to_grant", b_mcu_grant, 1'b1);
        b_cop_req = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("to_hold", b_mcu_grant, 1'b1);
            check("to_no_pulse", b_timeout, 1'b0);
        end
        tick();
        check("to_drop", b_mcu_grant, 1'b0);
        check("to_pulse", b_timeout, 1'b1);
        check("to_busy", b_busy, 1'b1);
        tick();
        check("to_pulse_end", b_timeout, 1'b0);
        check("to_cop_wait1", b_cop_grant, 1'b0);
        tick();
        check("to_cop_wait2", b_cop_grant, 1'b0);
        tick();
        check("to_cop_grant", b_cop_grant, 1'b1);
        check("to_mcu_off", b_mcu_grant, 1'b0);

        // Reset in the middle of a COP ownership.
        b_cop_nss = 1'b0;
        tick();
        check("mid_nss_low", b_ram_nss, 1'b0);
        reset = 1'b1;
        tick();
        check("mid_rst_cop", b_cop_grant, 1'b0);
        check("mid_rst_mcu", b_mcu_grant, 1'b0);
        check("mid_rst_nss", b_ram_nss, 1'b1);
        check("mid_rst_pulse", b_timeout, 1'b0);
        check("mid_rst_busy", b_busy, 1'b0);

        // Release on the same edge the timeout would fire: no pulse.
        reset = 1'b0; b_cop_req = 1'b0; b_cop_nss = 1'b1;
        tick();
        check("rt_grant", b_mcu_grant, 1'b1);
        b_cop_req = 1'b1;
        repeat (15) tick();
        check("rt_hold", b_mcu_grant, 1'b1);
        b_mcu_req = 1'b0;
        tick();
        check("rt_drop", b_mcu_grant, 1'b0);
        check("rt_no_pulse", b_timeout, 1'b0);
        wait_grant(1'b1, got_cop, n);
        check("rt_cop_after", got_cop, 1'b1);
        check("rt_cop_lat", n == 3, 1'b1);

        b_cop_req = 1'b0;
        repeat (5) tick();
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
